// File: rtl/path_buf_pkg.sv
// Shared types and default sizes for the maze-solver path buffer.
package path_buf_pkg;
  typedef enum logic [1:0] {
    MODE_STACK  = 2'd0,
    MODE_REPLAY = 2'd1,
    MODE_DONE   = 2'd2
  } path_mode_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 256;
endpackage

// File: rtl/path_buf_ram.sv
// Simple dual-port path storage: one write port, one registered read port.
module path_buf_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [AW-1:0]     rdAddr,
  output logic [DATA_W-1:0] rdData
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Read-first: a same-address write and read return the old word (replace-top).
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end
endmodule

// File: rtl/path_stack_replay.sv
// Path buffer: LIFO during search, FIFO-order replay of the stored path afterwards.
module path_stack_replay
  import path_buf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              replay_start,
  input  logic              replay_req,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output path_mode_t        mode,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              replay_done,
  output logic              overflow,
  output logic              underflow
);
  localparam int AW = $clog2(DEPTH);

  path_mode_t        modeReg;
  logic [CNT_W-1:0]  countReg, rdPtr;
  logic              validReg, ovfReg, unfReg;
  logic              outZero;
  logic              isFull, isEmpty, stackEmpty;
  logic              ramWe, ramRe;
  logic [AW-1:0]     ramWa, ramRa, topAddr;
  logic [DATA_W-1:0] ramRd;

  assign isFull     = (countReg == CNT_W'(DEPTH));
  assign stackEmpty = (countReg == '0);
  assign isEmpty    = (modeReg == MODE_STACK) ? stackEmpty : (rdPtr == countReg);
  // Wraps correctly when full: DEPTH maps to 0, minus one gives DEPTH-1.
  assign topAddr    = countReg[AW-1:0] - AW'(1);

  always_comb begin
    ramWe = 1'b0;
    ramRe = 1'b0;
    ramWa = countReg[AW-1:0];
    ramRa = topAddr;
    if (!clr && modeReg == MODE_STACK && !replay_start) begin
      if (push && pop && !stackEmpty) begin
        ramWe = 1'b1;
        ramWa = topAddr;
        ramRe = 1'b1;
      end else if (push && !isFull) begin
        ramWe = 1'b1;
      end else if (pop && !push && !stackEmpty) begin
        ramRe = 1'b1;
      end
    end else if (!clr && modeReg == MODE_REPLAY && replay_req) begin
      ramRe = 1'b1;
      ramRa = rdPtr[AW-1:0];
    end
  end

  path_buf_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) uRam (
    .clk    (clk),
    .wrEn   (ramWe),
    .wrAddr (ramWa),
    .wrData (push_data),
    .rdEn   (ramRe),
    .rdAddr (ramRa),
    .rdData (ramRd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modeReg  <= MODE_STACK;
      countReg <= '0;
      rdPtr    <= '0;
      validReg <= 1'b0;
      ovfReg   <= 1'b0;
      unfReg   <= 1'b0;
      outZero  <= 1'b1;
    end else if (clr) begin
      modeReg  <= MODE_STACK;
      countReg <= '0;
      rdPtr    <= '0;
      validReg <= 1'b0;
      ovfReg   <= 1'b0;
      unfReg   <= 1'b0;
      outZero  <= 1'b1;
    end else begin
      validReg <= ramRe;
      if (ramRe) outZero <= 1'b0;
      case (modeReg)
        MODE_STACK: begin
          if (replay_start) begin
            rdPtr   <= '0;
            modeReg <= stackEmpty ? MODE_DONE : MODE_REPLAY;
          end else if (push && pop) begin
            if (stackEmpty) begin
              countReg <= countReg + CNT_W'(1);
              unfReg   <= 1'b1;
            end
          end else if (push) begin
            if (isFull) ovfReg <= 1'b1;
            else        countReg <= countReg + CNT_W'(1);
          end else if (pop) begin
            if (stackEmpty) unfReg <= 1'b1;
            else            countReg <= countReg - CNT_W'(1);
          end
        end
        MODE_REPLAY: begin
          if (replay_req) begin
            rdPtr <= rdPtr + CNT_W'(1);
            if (rdPtr == countReg - CNT_W'(1)) modeReg <= MODE_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out    = outZero ? '0 : ramRd;
  assign data_valid  = validReg;
  assign mode        = modeReg;
  assign count       = countReg;
  assign full        = isFull;
  assign empty       = isEmpty;
  assign replay_done = (modeReg == MODE_DONE);
  assign overflow    = ovfReg;
  assign underflow   = unfReg;
endmodule
